// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback path.
// Used by rf_wb_arbiter (optional RF_WB_RR_ARB_EN round-robin build) and rf_sb.
package rf_pkg;

    localparam int RF_DW     = 32;
    localparam int RF_AW     = 4;
    localparam int RF_NREG   = 16;
    localparam int RF_PC_IDX = 15;

    typedef struct packed {
        logic [RF_AW-1:0] rd;
        logic [RF_DW-1:0] data;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

endpackage

// File: rtl/rf_sb.sv
// Busy scoreboard: decode reserves destinations, accepted writebacks release them.
// Also answers the two-source RAW hazard query for decode.
module rf_sb
    import rf_pkg::*;
#(
    parameter int AW     = RF_AW,
    parameter int NREG   = RF_NREG,
    parameter int PC_IDX = RF_PC_IDX
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic            rsv_valid,
    input  logic [AW-1:0]   rsv_rd,
    input  logic            clr_valid,
    input  logic [AW-1:0]   clr_rd,
    input  logic [AW-1:0]   q_ra,
    input  logic [AW-1:0]   q_rb,
    output logic            stall,
    output logic [NREG-1:0] busy,
    output logic            err_rsv
);

    localparam logic [AW-1:0] PC_RD = AW'(PC_IDX);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            err_rsv_q;
    logic            err_rsv_d;
    logic            set_en;

    assign set_en = rsv_valid && (rsv_rd != PC_RD);

    // Set beats clear on the same register, so a fresh reservation survives its predecessor's writeback.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            localparam logic [AW-1:0] IDX = AW'(gi);
            if (gi == PC_IDX) begin : g_pc
                assign busy_d[gi] = 1'b0;
            end else begin : g_reg
                assign busy_d[gi] = (set_en && rsv_rd == IDX) ||
                                    (busy_q[gi] && !(clr_valid && clr_rd == IDX));
            end
        end
    endgenerate

    always_comb begin
        err_rsv_d = set_en && busy_q[rsv_rd] && !(clr_valid && clr_rd == rsv_rd);
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            busy_q    <= '0;
            err_rsv_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            err_rsv_q <= err_rsv_d;
        end
    end

    assign busy    = busy_q;
    assign err_rsv = err_rsv_q;
    assign stall   = busy_q[q_ra] | busy_q[q_rb];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port.
// Define RF_WB_RR_ARB_EN for round-robin; otherwise MEM has fixed priority over ALU.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DW     = RF_DW,
    parameter int AW     = RF_AW,
    parameter int NREG   = RF_NREG,
    parameter int PC_IDX = RF_PC_IDX
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [DW-1:0]   alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_rd,
    input  logic [DW-1:0]   mem_data,
    input  logic            rsv_valid,
    input  logic [AW-1:0]   rsv_rd,
    input  logic [AW-1:0]   q_ra,
    input  logic [AW-1:0]   q_rb,
    output logic            stall,
    output logic            RegWrite,
    output logic [AW-1:0]   Rw,
    output logic [DW-1:0]   RFin,
    output logic [NREG-1:0] busy,
    output logic            err_pc_wr,
    output logic            err_rsv
);

    localparam logic [AW-1:0] PC_RD = AW'(PC_IDX);

    wb_req_t       alu_req;
    wb_req_t       mem_req;
    wb_req_t       sel_req;
    logic          grant_mem;
    logic          accept;
    logic          pc_hit;

    logic          regwrite_q, regwrite_d;
    logic [AW-1:0] rw_q, rw_d;
    logic [DW-1:0] rfin_q, rfin_d;
    logic          err_pc_wr_q, err_pc_wr_d;

    assign alu_req = '{rd: alu_rd, data: alu_data};
    assign mem_req = '{rd: mem_rd, data: mem_data};

`ifdef RF_WB_RR_ARB_EN
    src_e rr_q, rr_d;

    // Pointer names the source that wins the next contest; only contests move it.
    always_comb begin
        grant_mem = mem_valid && (!alu_valid || rr_q == SRC_MEM);
        rr_d      = rr_q;
        if (alu_valid && mem_valid) begin
            rr_d = grant_mem ? SRC_ALU : SRC_MEM;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            rr_q <= SRC_MEM;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        grant_mem = mem_valid;
    end
`endif

    assign mem_ready = grant_mem;
    assign alu_ready = alu_valid && !grant_mem;

    // PC-targeted requests are still accepted so the requester drains; only the write is suppressed.
    always_comb begin
        sel_req     = grant_mem ? mem_req : alu_req;
        accept      = alu_ready || mem_ready;
        pc_hit      = (sel_req.rd == PC_RD);
        regwrite_d  = accept && !pc_hit;
        err_pc_wr_d = accept && pc_hit;
        rw_d        = rw_q;
        rfin_d      = rfin_q;
        if (regwrite_d) begin
            rw_d   = sel_req.rd;
            rfin_d = sel_req.data;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            regwrite_q  <= 1'b0;
            rw_q        <= '0;
            rfin_q      <= '0;
            err_pc_wr_q <= 1'b0;
        end else begin
            regwrite_q  <= regwrite_d;
            rw_q        <= rw_d;
            rfin_q      <= rfin_d;
            err_pc_wr_q <= err_pc_wr_d;
        end
    end

    assign RegWrite  = regwrite_q;
    assign Rw        = rw_q;
    assign RFin      = rfin_q;
    assign err_pc_wr = err_pc_wr_q;

    rf_sb #(
        .AW     (AW),
        .NREG   (NREG),
        .PC_IDX (PC_IDX)
    ) u_sb (
        .clk       (clk),
        .Reset     (Reset),
        .rsv_valid (rsv_valid),
        .rsv_rd    (rsv_rd),
        .clr_valid (accept),
        .clr_rd    (sel_req.rd),
        .q_ra      (q_ra),
        .q_rb      (q_rb),
        .stall     (stall),
        .busy      (busy),
        .err_rsv   (err_rsv)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (arbitration, scoreboard, PC guard, async reset).
// Contest expectations follow RF_WB_RR_ARB_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        Reset;
    logic        alu_valid, mem_valid, rsv_valid;
    logic        alu_ready, mem_ready;
    logic [3:0]  alu_rd, mem_rd, rsv_rd, q_ra, q_rb;
    logic [31:0] alu_data, mem_data;
    logic        stall, RegWrite, err_pc_wr, err_rsv;
    logic [3:0]  Rw;
    logic [31:0] RFin;
    logic [15:0] busy;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk       (clk),
        .Reset     (Reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .rsv_valid (rsv_valid),
        .rsv_rd    (rsv_rd),
        .q_ra      (q_ra),
        .q_rb      (q_rb),
        .stall     (stall),
        .RegWrite  (RegWrite),
        .Rw        (Rw),
        .RFin      (RFin),
        .busy      (busy),
        .err_pc_wr (err_pc_wr),
        .err_rsv   (err_rsv)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        alu_valid = 0; mem_valid = 0; rsv_valid = 0;
        alu_rd = 0; mem_rd = 0; rsv_rd = 0; q_ra = 0; q_rb = 0;
        alu_data = 0; mem_data = 0;
        #12;
        tests_run++;
        if ({RegWrite, err_pc_wr, err_rsv, stall, alu_ready, mem_ready} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {RegWrite, err_pc_wr, err_rsv, stall, alu_ready, mem_ready});
        end
        tests_run++;
        if (busy !== 16'h0 || Rw !== 4'h0 || RFin !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%h Rw=%h RFin=%h expected all 0", busy, Rw, RFin);
        end
        #1 Reset = 1'b1;
        tick();
        $display("[TB] reset released");
    endtask

    task automatic test_single_alu();
        alu_valid = 1; alu_rd = 4'd3; alu_data = 32'hDEADBEEF;
        #1;
        tests_run++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_ready: alu_ready=%b mem_ready=%b expected 1 0", alu_ready, mem_ready);
        end
        tick();
        alu_valid = 0;
        tests_run++;
        if (RegWrite !== 1'b1 || Rw !== 4'd3 || RFin !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL single_write: RegWrite=%b Rw=%h RFin=%h expected 1 3 deadbeef", RegWrite, Rw, RFin);
        end
        tick();
        tests_run++;
        if (RegWrite !== 1'b0 || Rw !== 4'd3 || RFin !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL single_idle: RegWrite=%b Rw=%h RFin=%h expected 0 3 deadbeef", RegWrite, Rw, RFin);
        end
        $display("[TB] single ALU write rd=3 checked");
    endtask

    task automatic test_contest();
        alu_valid = 1; alu_rd = 4'd1; alu_data = 32'h11;
        mem_valid = 1; mem_rd = 4'd2; mem_data = 32'h22;
        #1;
        tests_run++;
        if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL contest1_grant: mem_ready=%b alu_ready=%b expected 1 0", mem_ready, alu_ready);
        end
        tick();
        mem_valid = 0;
        #1;
        tests_run++;
        if (RegWrite !== 1'b1 || Rw !== 4'd2 || RFin !== 32'h22 || alu_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL contest1_mem: RegWrite=%b Rw=%h RFin=%h alu_ready=%b expected 1 2 22 1",
                     RegWrite, Rw, RFin, alu_ready);
        end
        tick();
        alu_valid = 0;
        tests_run++;
        if (RegWrite !== 1'b1 || Rw !== 4'd1 || RFin !== 32'h11) begin
            tests_failed++;
            $display("FAIL contest1_alu: RegWrite=%b Rw=%h RFin=%h expected 1 1 11", RegWrite, Rw, RFin);
        end
        // Second contest
        alu_valid = 1; alu_rd = 4'd1; alu_data = 32'h33;
        mem_valid = 1; mem_rd = 4'd2; mem_data = 32'h44;
        #1;
        tests_run++;
`ifdef RF_WB_RR_ARB_EN
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL contest2_grant: alu_ready=%b mem_ready=%b expected 1 0", alu_ready, mem_ready);
        end
        tick();
        alu_valid = 0;
        tests_run++;
        if (Rw !== 4'd1 || RFin !== 32'h33) begin
            tests_failed++;
            $display("FAIL contest2_first: Rw=%h RFin=%h expected 1 33", Rw, RFin);
        end
        tick();
        mem_valid = 0;
        tests_run++;
        if (Rw !== 4'd2 || RFin !== 32'h44) begin
            tests_failed++;
            $display("FAIL contest2_second: Rw=%h RFin=%h expected 2 44", Rw, RFin);
        end
`else
        if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL contest2_grant: mem_ready=%b alu_ready=%b expected 1 0", mem_ready, alu_ready);
        end
        tick();
        mem_valid = 0;
        tests_run++;
        if (Rw !== 4'd2 || RFin !== 32'h44) begin
            tests_failed++;
            $display("FAIL contest2_first: Rw=%h RFin=%h expected 2 44", Rw, RFin);
        end
        tick();
        alu_valid = 0;
        tests_run++;
        if (Rw !== 4'd1 || RFin !== 32'h33) begin
            tests_failed++;
            $display("FAIL contest2_second: Rw=%h RFin=%h expected 1 33", Rw, RFin);
        end
`endif
        tick();
        $display("[TB] two contests ALU rd=1 vs MEM rd=2 checked");
    endtask

    task automatic test_back_to_back();
        alu_valid = 1; alu_rd = 4'd8; alu_data = 32'h88;
        tick();
        alu_rd = 4'd9; alu_data = 32'h99;
        tests_run++;
        if (RegWrite !== 1'b1 || Rw !== 4'd8 || RFin !== 32'h88) begin
            tests_failed++;
            $display("FAIL b2b_first: RegWrite=%b Rw=%h RFin=%h expected 1 8 88", RegWrite, Rw, RFin);
        end
        tick();
        alu_valid = 0;
        tests_run++;
        if (RegWrite !== 1'b1 || Rw !== 4'd9 || RFin !== 32'h99) begin
            tests_failed++;
            $display("FAIL b2b_second: RegWrite=%b Rw=%h RFin=%h expected 1 9 99", RegWrite, Rw, RFin);
        end
        tick();
        $display("[TB] back-to-back writes rd=8, rd=9 checked");
    endtask

    task automatic test_hazard();
        rsv_valid = 1; rsv_rd = 4'd5;
        tick();
        rsv_valid = 0;
        q_ra = 4'd5; q_rb = 4'd0;
        #1;
        tests_run++;
        if (busy !== 16'h0020 || stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL hazard_set: busy=%h stall=%b expected 0020 1", busy, stall);
        end
        q_ra = 4'd0; q_rb = 4'd5;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL hazard_rb: stall=%b expected 1", stall);
        end
        mem_valid = 1; mem_rd = 4'd5; mem_data = 32'h55;
        tick();
        mem_valid = 0;
        tests_run++;
        if (busy[5] !== 1'b0 || stall !== 1'b0 || RegWrite !== 1'b1 || Rw !== 4'd5) begin
            tests_failed++;
            $display("FAIL hazard_clear: busy5=%b stall=%b RegWrite=%b Rw=%h expected 0 0 1 5",
                     busy[5], stall, RegWrite, Rw);
        end
        q_rb = 4'd0;
        tick();
        $display("[TB] reserve/clear of rd=5 checked");
    endtask

    task automatic test_set_clear();
        rsv_valid = 1; rsv_rd = 4'd7;
        tick();
        alu_valid = 1; alu_rd = 4'd7; alu_data = 32'h77;
        tick();
        rsv_valid = 0; alu_valid = 0;
        tests_run++;
        if (busy[7] !== 1'b1 || err_rsv !== 1'b0) begin
            tests_failed++;
            $display("FAIL setclr_same: busy7=%b err_rsv=%b expected 1 0", busy[7], err_rsv);
        end
        rsv_valid = 1;
        tick();
        rsv_valid = 0;
        tests_run++;
        if (err_rsv !== 1'b1 || busy[7] !== 1'b1) begin
            tests_failed++;
            $display("FAIL rsv_dup: err_rsv=%b busy7=%b expected 1 1", err_rsv, busy[7]);
        end
        tick();
        tests_run++;
        if (err_rsv !== 1'b0) begin
            tests_failed++;
            $display("FAIL rsv_pulse: err_rsv=%b expected 0", err_rsv);
        end
        $display("[TB] set/clear collision and duplicate reservation of rd=7 checked");
    endtask

    task automatic test_pc_guard();
        alu_valid = 1; alu_rd = 4'd15; alu_data = 32'h100;
        #1;
        tests_run++;
        if (alu_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL pc_ready: alu_ready=%b expected 1", alu_ready);
        end
        tick();
        alu_valid = 0;
        tests_run++;
        if (RegWrite !== 1'b0 || err_pc_wr !== 1'b1) begin
            tests_failed++;
            $display("FAIL pc_drop: RegWrite=%b err_pc_wr=%b expected 0 1", RegWrite, err_pc_wr);
        end
        rsv_valid = 1; rsv_rd = 4'd15;
        tick();
        rsv_valid = 0;
        tests_run++;
        if (err_pc_wr !== 1'b0 || busy[15] !== 1'b0 || err_rsv !== 1'b0) begin
            tests_failed++;
            $display("FAIL pc_rsv: err_pc_wr=%b busy15=%b err_rsv=%b expected 0 0 0", err_pc_wr, busy[15], err_rsv);
        end
        $display("[TB] PC write drop and PC reservation checked");
    endtask

    task automatic test_async_reset();
        alu_valid = 1; alu_rd = 4'd4; alu_data = 32'h44;
        tick();
        alu_valid = 0;
        tests_run++;
        if (RegWrite !== 1'b1 || busy[7] !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_pre: RegWrite=%b busy7=%b expected 1 1", RegWrite, busy[7]);
        end
        #1 Reset = 1'b0;
        #1;
        tests_run++;
        if (RegWrite !== 1'b0 || busy !== 16'h0 || err_pc_wr !== 1'b0 || err_rsv !== 1'b0 || Rw !== 4'h0) begin
            tests_failed++;
            $display("FAIL areset_now: RegWrite=%b busy=%h err_pc_wr=%b err_rsv=%b Rw=%h expected 0 0000 0 0 0",
                     RegWrite, busy, err_pc_wr, err_rsv, Rw);
        end
        tick();
        Reset = 1'b1;
        tick();
        tests_run++;
        if (RegWrite !== 1'b0 || busy !== 16'h0) begin
            tests_failed++;
            $display("FAIL areset_after: RegWrite=%b busy=%h expected 0 0000", RegWrite, busy);
        end
        $display("[TB] asynchronous reset mid-operation checked");
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_contest();
        test_back_to_back();
        test_hazard();
        test_set_clear();
        test_pc_guard();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
